// File: rtl/parser_pkg.sv
// Shared types and constants for the parser front end.
// Lane/beat/window typedefs, the window-builder state enum and geometry
// constants used by hdr_window_builder and hdr_lane_writer.
package parser_pkg;

    localparam int CANDI_NUM     = 128;  // window depth in lanes (bytes)
    localparam int OFFSET_WIDTH  = 7;    // log2(CANDI_NUM)
    localparam int EXTRACT_WIDTH = 8;    // lane width in bits
    localparam int BEAT_BYTES    = 16;   // lanes per input beat
    localparam int BEAT_CNT_W    = 5;    // holds 0..BEAT_BYTES

    typedef logic [EXTRACT_WIDTH-1:0] lane_t;
    typedef lane_t [CANDI_NUM-1:0]    window_t;
    typedef lane_t [BEAT_BYTES-1:0]   beat_t;
    typedef logic [OFFSET_WIDTH:0]    len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/hdr_lane_writer.sv
// Combinational lane writer for the header window.
// Ports:
//   win_in  - current window contents
//   beat    - incoming beat lanes, lane 0 = earliest byte
//   base    - window lane where beat lane 0 lands (always beat aligned)
//   cnt     - number of valid beat lanes to write
//   win_out - window with lanes [base, base+cnt) replaced by the beat
module hdr_lane_writer
    import parser_pkg::*;
(
    input  logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0]  win_in,
    input  logic [BEAT_BYTES-1:0][EXTRACT_WIDTH-1:0] beat,
    input  logic [OFFSET_WIDTH:0]                    base,
    input  logic [BEAT_CNT_W-1:0]                    cnt,
    output logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0]  win_out
);

    // One extra bit so base+cnt cannot wrap even at the window end.
    localparam int CMP_W = OFFSET_WIDTH + 2;

    logic [CMP_W-1:0]     lo;
    logic [CMP_W-1:0]     hi;
    logic [CANDI_NUM-1:0] lane_we;

    assign lo = CMP_W'(base);
    assign hi = CMP_W'(base) + CMP_W'(cnt);

    // base is always a multiple of BEAT_BYTES, so window lane g maps to
    // beat lane g % BEAT_BYTES and no per-lane shifter is needed.
    for (genvar g = 0; g < CANDI_NUM; g++) begin : g_lane
        localparam logic [CMP_W-1:0] LANE = CMP_W'(g);
        assign lane_we[g] = (LANE >= lo) && (LANE < hi);
        assign win_out[g] = lane_we[g] ? beat[g % BEAT_BYTES] : win_in[g];
    end

endmodule

// File: rtl/hdr_window_builder.sv
// Header window builder: collects the first CANDI_NUM bytes of each packet
// from a byte-beat stream into a flat lane window for the extract units,
// presents it with its captured length, and discards the packet remainder.
// Ports:
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_beat_valid / o_beat_ready  - input beat handshake
//   i_beat_data, i_sop, i_eop    - beat lanes and packet delimiters
//   i_bytes                      - valid lanes on the eop beat
//   o_window, o_hdr_len          - assembled window and captured byte count
//   o_win_valid / i_win_ready    - window handshake
//   o_err                        - one-cycle protocol error pulse
//
// state | meaning
// IDLE  | waiting for a sop beat
// FILL  | capturing beats into the window
// DRAIN | window full, discarding beats up to eop
// HOLD  | packet done, holding window until the consumer takes it
module hdr_window_builder
    import parser_pkg::*;
(
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_beat_valid,
    output logic                                     o_beat_ready,
    input  logic [BEAT_BYTES-1:0][EXTRACT_WIDTH-1:0] i_beat_data,
    input  logic                                     i_sop,
    input  logic                                     i_eop,
    input  logic [BEAT_CNT_W-1:0]                    i_bytes,
    output logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0]  o_window,
    output logic [OFFSET_WIDTH:0]                    o_hdr_len,
    output logic                                     o_win_valid,
    input  logic                                     i_win_ready,
    output logic                                     o_err
);

    if (CANDI_NUM % BEAT_BYTES != 0) begin : g_bad_geometry
        $error("CANDI_NUM must be a multiple of BEAT_BYTES");
    end
    if (OFFSET_WIDTH != $clog2(CANDI_NUM)) begin : g_bad_offset
        $error("OFFSET_WIDTH must equal log2(CANDI_NUM)");
    end

    state_t                state;
    window_t               wr_win_in;
    window_t               wr_win_out;
    len_t                  wr_base;
    len_t                  new_len;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  bytes_err;
    logic                  beat_xfer;
    logic                  win_xfer;
    logic                  drain_stall;
    logic                  capture;

    // Non-eop beats are always full; an eop with 0 bytes is an error and
    // contributes nothing. Oversized counts are clamped to a full beat.
    always_comb begin
        beat_cnt  = BEAT_CNT_W'(BEAT_BYTES);
        bytes_err = 1'b0;
        if (i_eop) begin
            if (i_bytes == '0) begin
                beat_cnt  = '0;
                bytes_err = 1'b1;
            end else if (i_bytes < BEAT_CNT_W'(BEAT_BYTES)) begin
                beat_cnt = i_bytes;
            end
        end
    end

    // A sop arriving in DRAIN before the window has gone is held off: the
    // packet is closed as if eop had been seen and the sop beat waits.
    assign drain_stall  = (state == DRAIN) && o_win_valid && i_beat_valid && i_sop;
    assign o_beat_ready = !i_rst && (state != HOLD) && !drain_stall;
    assign beat_xfer    = i_beat_valid && o_beat_ready;
    assign win_xfer     = o_win_valid && i_win_ready;

    // sop always (re)starts a window; FILL beats extend it. A sop beat that
    // transfers in DRAIN is only possible once the window has gone.
    assign capture   = beat_xfer && (i_sop || (state == FILL));
    assign wr_base   = i_sop ? '0 : o_hdr_len;
    assign wr_win_in = i_sop ? '0 : o_window;
    assign new_len   = wr_base + len_t'(beat_cnt);

    hdr_lane_writer u_lane_writer (
        .win_in  (wr_win_in),
        .beat    (i_beat_data),
        .base    (wr_base),
        .cnt     (beat_cnt),
        .win_out (wr_win_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_window    <= '0;
            o_hdr_len   <= '0;
            o_win_valid <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (capture) begin
                o_window  <= wr_win_out;
                o_hdr_len <= new_len;
                o_err     <= bytes_err || (i_sop && (state != IDLE));
                if (i_eop) begin
                    state       <= HOLD;
                    o_win_valid <= 1'b1;
                end else if (new_len == len_t'(CANDI_NUM)) begin
                    state       <= DRAIN;
                    o_win_valid <= 1'b1;
                end else begin
                    state <= FILL;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (beat_xfer) begin
                            o_err <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (win_xfer) begin
                            o_win_valid <= 1'b0;
                        end
                        if (drain_stall) begin
                            o_err <= 1'b1;
                            state <= win_xfer ? IDLE : HOLD;
                        end else if (beat_xfer) begin
                            o_err <= bytes_err;
                            if (i_eop) begin
                                state <= (o_win_valid && !win_xfer) ? HOLD : IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (win_xfer) begin
                            o_win_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdr_window_builder.sv
module tb_hdr_window_builder;
    import parser_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_beat_valid = 1'b0;
    logic        o_beat_ready;
    beat_t       i_beat_data = '0;
    logic        i_sop = 1'b0;
    logic        i_eop = 1'b0;
    logic [BEAT_CNT_W-1:0] i_bytes = '0;
    window_t     o_window;
    len_t        o_hdr_len;
    logic        o_win_valid;
    logic        i_win_ready = 1'b0;
    logic        o_err;

    hdr_window_builder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_beat_valid (i_beat_valid),
        .o_beat_ready (o_beat_ready),
        .i_beat_data  (i_beat_data),
        .i_sop        (i_sop),
        .i_eop        (i_eop),
        .i_bytes      (i_bytes),
        .o_window     (o_window),
        .o_hdr_len    (o_hdr_len),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_err        (o_err)
    );

    initial forever #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int err_seen = 0;
    int n_pushed = 0;
    int n_popped = 0;
    bit rand_ready = 1'b0;
    bit rand_gaps = 1'b0;

    logic [7:0] cur_pkt[$];
    window_t    exp_win_q[$];
    int         exp_len_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_win(input string name, input window_t act, input window_t exp);
        int bad;
        bad = -1;
        for (int k = CANDI_NUM - 1; k >= 0; k--) if (act[k] !== exp[k]) bad = k;
        n_total++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: lane %0d got %02h expected %02h", name, bad, act[bad], exp[bad]);
    endtask

    // Reference: the window is the first min(len, CANDI_NUM) packet bytes, zero beyond.
    task automatic push_expect();
        window_t w;
        int n;
        w = '0;
        n = (cur_pkt.size() < CANDI_NUM) ? cur_pkt.size() : CANDI_NUM;
        for (int k = 0; k < n; k++) w[k] = cur_pkt[k];
        exp_win_q.push_back(w);
        exp_len_q.push_back(n);
        n_pushed++;
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_err) err_seen++;
            if (o_win_valid && i_win_ready) begin
                if (exp_win_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_window: got window len %0d with none expected", o_hdr_len);
                end else begin
                    check_int("hdr_len", int'(o_hdr_len), exp_len_q.pop_front());
                    check_win("window", o_window, exp_win_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_ready) i_win_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input beat_t d, input logic sop, input logic eop,
                             input logic [BEAT_CNT_W-1:0] nb, output int t);
        logic r;
        int w;
        r = 1'b0;
        w = 0;
        i_beat_data = d; i_sop = sop; i_eop = eop; i_bytes = nb; i_beat_valid = 1'b1;
        while (!r && w < 500) begin
            @(negedge i_clk);
            r = o_beat_ready;
            tick();
            w++;
        end
        i_beat_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        t = cyc;
        if (!r) begin
            n_total++;
            $display("FAIL beat_accept_timeout: ready stayed 0 for %0d cycles, required 1", w);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t d;
        for (int j = 0; j < BEAT_BYTES; j++) d[j] = 8'($urandom);
        return d;
    endfunction

    // Sends a legal plen-byte packet. exp_vb > 0 also checks, after every
    // beat, that o_win_valid is high exactly from beat exp_vb onward.
    task automatic send_packet(input int plen, input int exp_vb, output int t0, output int t1);
        int nb, idx, t;
        beat_t d;
        logic last;
        logic [BEAT_CNT_W-1:0] cnt;
        cur_pkt.delete();
        for (int k = 0; k < plen; k++) cur_pkt.push_back(8'($urandom));
        push_expect();
        nb = (plen + BEAT_BYTES - 1) / BEAT_BYTES;
        t0 = 0; t1 = 0;
        for (int b = 0; b < nb; b++) begin
            d = rand_beat();
            for (int j = 0; j < BEAT_BYTES; j++) begin
                idx = b * BEAT_BYTES + j;
                if (idx < plen) d[j] = cur_pkt[idx];
            end
            last = (b == nb - 1);
            cnt = last ? BEAT_CNT_W'(plen - b * BEAT_BYTES) : BEAT_CNT_W'($urandom_range(0, 31));
            if (rand_gaps && $urandom_range(0, 3) == 0) tick();
            send_beat(d, b == 0, last, cnt, t);
            if (b == 0) t0 = t;
            t1 = t;
            if (exp_vb > 0) begin
                @(negedge i_clk);
                check_int("win_valid_rise", int'(o_win_valid), (b + 1 >= exp_vb) ? 1 : 0);
                tick();
            end
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_win_q.size() > 0 && w < 2000) begin tick(); w++; end
        check_int("windows_outstanding", exp_win_q.size(), 0);
    endtask

    typedef struct {
        int plen;
        int hold_cycles;
        int exp_len;
        int exp_vb;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0, t1, t2, t3, e0, dummy;
        beat_t d;

        vecs[0] = '{40, 3, 40, 3};
        vecs[1] = '{5, 10, 5, 1};
        vecs[2] = '{16, 0, 16, 1};
        vecs[3] = '{128, 2, 128, 8};
        vecs[4] = '{300, 2, 128, 8};
        vecs[5] = '{129, 1, 128, 8};
        vecs[6] = '{17, 1, 17, 2};

        // Reset state
        tick(); tick();
        @(negedge i_clk);
        check_int("rst_ready", int'(o_beat_ready), 0);
        check_int("rst_win_valid", int'(o_win_valid), 0);
        check_int("rst_hdr_len", int'(o_hdr_len), 0);
        check_int("rst_err", int'(o_err), 0);
        check_win("rst_window", o_window, '0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_int("idle_ready", int'(o_beat_ready), 1);
        tick();

        // Table: capture, HOLD backpressure, return to IDLE
        for (int v = 0; v < 7; v++) begin
            i_win_ready = 1'b0;
            send_packet(vecs[v].plen, vecs[v].exp_vb, t0, t1);
            for (int h = 0; h < vecs[v].hold_cycles; h++) begin
                @(negedge i_clk);
                check_int("hold_ready", int'(o_beat_ready), 0);
                check_int("hold_len", int'(o_hdr_len), vecs[v].exp_len);
                if (exp_win_q.size() > 0) check_win("hold_window", o_window, exp_win_q[0]);
                tick();
            end
            i_win_ready = 1'b1;
            tick();
            i_win_ready = 1'b0;
            @(negedge i_clk);
            check_int("post_xfer_valid", int'(o_win_valid), 0);
            check_int("post_xfer_ready", int'(o_beat_ready), 1);
            tick();
        end
        check_int("table_windows", n_popped, 7);

        // Long packet drained at full rate, back-to-back sop right after eop
        i_win_ready = 1'b1;
        send_packet(300, 0, t0, t1);
        send_packet(16, 0, t2, t3);
        check_int("drain_rate", t1 - t0, 18);
        check_int("b2b_sop", t2 - t1, 1);
        wait_drain();

        // Beat without sop in IDLE
        e0 = err_seen;
        send_beat(rand_beat(), 1'b0, 1'b0, 5'd16, dummy);
        tick(); tick();
        check_int("nosop_err", err_seen - e0, 1);
        check_int("nosop_valid", int'(o_win_valid), 0);

        // sop in the middle of FILL restarts the window
        e0 = err_seen;
        send_beat(rand_beat(), 1'b1, 1'b0, 5'd0, dummy);
        send_beat(rand_beat(), 1'b0, 1'b0, 5'd3, dummy);
        send_packet(20, 0, t0, t1);
        wait_drain();
        check_int("midfill_sop_err", err_seen - e0, 1);

        // eop with zero bytes: error, beat contributes nothing
        e0 = err_seen;
        cur_pkt.delete();
        push_expect();
        d = rand_beat();
        send_beat(d, 1'b1, 1'b1, 5'd0, dummy);
        wait_drain();
        check_int("zero_bytes_err", err_seen - e0, 1);

        // Reset during FILL
        e0 = err_seen;
        i_win_ready = 1'b0;
        send_beat(rand_beat(), 1'b1, 1'b0, 5'd16, dummy);
        send_beat(rand_beat(), 1'b0, 1'b0, 5'd16, dummy);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_int("rst_fill_ready", int'(o_beat_ready), 0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_int("rst_fill_valid", int'(o_win_valid), 0);
        check_int("rst_fill_len", int'(o_hdr_len), 0);
        check_int("rst_fill_ready_after", int'(o_beat_ready), 1);
        check_win("rst_fill_window", o_window, '0);
        tick();
        i_win_ready = 1'b1;
        send_packet(16, 1, t0, t1);
        wait_drain();
        check_int("rst_fill_no_err", err_seen - e0, 0);

        // Random traffic with backpressure on both sides
        e0 = err_seen;
        rand_ready = 1'b1;
        rand_gaps = 1'b1;
        for (int p = 0; p < 1000; p++) send_packet($urandom_range(1, 300), 0, t0, t1);
        rand_ready = 1'b0;
        rand_gaps = 1'b0;
        i_win_ready = 1'b1;
        wait_drain();
        check_int("random_no_err", err_seen - e0, 0);
        check_int("windows_delivered", n_popped, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hdr_window_builder.md
Name: hdr_window_builder

Overview:
- Upstream neighbour of the field-extract stage.
- Accepts a packet as a stream of byte beats with a valid/ready handshake.
- Assembles the first CANDI_NUM bytes of the packet into a flat register window of EXTRACT_WIDTH-bit lanes, which feeds the extract units' candidate-data input.
- Presents the window with a valid/ready handshake and its captured byte length, then discards the rest of the packet.

Parameters:
- CANDI_NUM, 128: window depth in lanes (bytes). Must be a multiple of BEAT_BYTES.
- OFFSET_WIDTH, 7: log2(CANDI_NUM). Lane index width, matching the extract offset field.
- EXTRACT_WIDTH, 8: lane width in bits.
- BEAT_BYTES, 16: lanes per input beat.
- BEAT_CNT_W, 5: width of the i_bytes field; holds 0..BEAT_BYTES.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high. Single clock domain.
- i_beat_valid  in  1  input beat valid.
- o_beat_ready  out  1  input beat ready.
- i_beat_data  in  [BEAT_BYTES-1:0][EXTRACT_WIDTH-1:0]  beat lanes; lane 0 is the earliest packet byte.
- i_sop  in  1  first beat of packet.
- i_eop  in  1  last beat of packet.
- i_bytes  in  BEAT_CNT_W  valid lanes in the beat (1..BEAT_BYTES). Sampled only when i_eop=1; otherwise the beat is taken as full.
- o_window  out  [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0]  assembled header window.
- o_hdr_len  out  OFFSET_WIDTH+1  bytes captured (0..CANDI_NUM).
- o_win_valid  out  1  window valid.
- i_win_ready  in  1  consumer accepts window.
- o_err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Transfer rules:
  - An input beat transfers when i_beat_valid & o_beat_ready.
  - A window transfers when o_win_valid & i_win_ready.
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE.
  - o_window, o_hdr_len, o_win_valid and o_err go to 0.
  - o_beat_ready is forced 0 while i_rst is high.
  - Reset mid-packet abandons the packet and any held window, with no error pulse.
- States:
  - IDLE: o_beat_ready=1.
    - Transfer with i_sop: clear the window, write the beat to lanes [BEAT_BYTES-1:0], set len = beat byte count.
    - Then go to HOLD if i_eop, else go to FILL.
    - Transfer without i_sop: drop the beat, pulse o_err, stay IDLE.
  - FILL: o_beat_ready=1.
    - Each beat writes lanes starting at the current len; len increases by the beat count.
    - Lanes past the eop byte count stay 0.
    - i_eop -> HOLD.
    - len reaching CANDI_NUM without eop -> DRAIN.
    - i_sop in FILL (missing eop): pulse o_err and restart the window with this beat, as in the IDLE sop case.
  - DRAIN: o_beat_ready=1. Beats are discarded.
    - i_eop -> HOLD if the window has not yet transferred, else IDLE.
    - i_sop in DRAIN: pulse o_err, then handle it as a new sop. This happens only after the window has transferred; otherwise treat it as eop plus a stalled beat, i.e. o_beat_ready drops.
  - HOLD: o_beat_ready=0. Window transfer -> IDLE.
- o_win_valid:
  - Registered.
  - Rises the cycle after the beat that completes capture is accepted: either the eop beat, or the beat that makes len=CANDI_NUM.
  - Stays high in DRAIN and HOLD until the window transfers.
  - A window transfer during DRAIN clears o_win_valid; the block stays in DRAIN.
- Stability: o_window and o_hdr_len are stable while o_win_valid=1. They are updated only by capture beats.
- Arithmetic:
  - len is an OFFSET_WIDTH+1-bit register.
  - Because of the multiple-of-BEAT_BYTES rule, len never exceeds CANDI_NUM and no beat straddles the window end.
  - o_hdr_len = len.
- A back-to-back packet sop can be accepted the cycle after the window transfer; throughput is one beat per cycle otherwise.
- i_bytes=0 on eop counts as a protocol error: o_err pulses and the beat is treated as 0 bytes.

Decomposition:
- Shared package parser_pkg:
  - lane/byte typedef (EXTRACT_WIDTH);
  - window typedef [CANDI_NUM-1:0] of lanes;
  - state enum {IDLE, FILL, DRAIN, HOLD};
  - constants CANDI_NUM, OFFSET_WIDTH, BEAT_BYTES.
- One sub-module, hdr_lane_writer: combinational, given the window, beat, base len and byte count, returns the next window. It holds the per-lane write-enable decode.
- Elaboration assertion: CANDI_NUM % BEAT_BYTES == 0.

Test Plan:
- 40-byte packet (3 beats, eop i_bytes=8), i_win_ready=1 -> o_win_valid high 1 cycle after the eop beat; o_hdr_len=40; lanes 40..127 = 0; lane k = byte k.
- 300-byte packet -> o_win_valid rises after beat 8; o_hdr_len=128; beats 9..19 are drained with o_beat_ready=1; the next sop is accepted right after eop.
- Single-beat packet (sop+eop, i_bytes=5) with i_win_ready=0 for 10 cycles -> o_beat_ready=0 throughout HOLD; window stable; IDLE the cycle after the handshake.
- Beat without sop in IDLE -> o_err pulses once, no window; sop mid-FILL -> o_err pulses; the window restarts with o_hdr_len counting from the new sop.
- i_rst asserted during FILL after 2 beats -> next cycle o_win_valid=0, o_hdr_len=0, state IDLE; a following 16-byte packet yields o_hdr_len=16.
- Random valid/ready backpressure on both sides over 1000 packets -> every window matches the scoreboard's first min(len,128) bytes; no window is lost or duplicated.
